// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared types and limits for pipeline register chains
package mips_pipe_pkg;

  // COLLAPSE squeezes bubbles out; LOCKSTEP shifts every stage together
  typedef enum logic {
    PIPE_COLLAPSE,
    PIPE_LOCKSTEP
  } pipe_mode_e;

  localparam int PIPE_MAX_DEPTH = 8;

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid-tagged register stage of a pipeline chain
module pipe_stage #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d,
  output logic             q_valid,
  output logic [WIDTH-1:0] q
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // next state: a bubble load only clears valid, data is kept to avoid toggling
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = d_valid;
      if (d_valid) begin
        data_d = d;
      end
    end
  end

  // reset and flush both return the stage to INIT with no valid word
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      valid_q <= 1'b0;
      data_q  <= INIT;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign q_valid = valid_q;
  assign q       = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - DEPTH-stage ready/valid pipeline register chain
module pipe_reg_chain
  import mips_pipe_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter pipe_mode_e       MODE  = PIPE_COLLAPSE
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_depth_check
    $error("pipe_reg_chain: DEPTH must be within 1..8");
  end

  logic [DEPTH-1:0] stg_valid;
  logic [WIDTH-1:0] stg_data [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] load;
  logic             adv;
  logic             in_xfer;
  logic             out_xfer;
  logic [OCC_W-1:0] occ_q, occ_d;

  // collapse ready chain: a stage can take a word if it is empty or anything downstream drains
  always_comb begin
    logic rdy_acc;
    rdy_acc = out_ready;
    rdy     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy_acc = rdy_acc || !stg_valid[i];
      rdy[i]  = rdy_acc;
    end
  end

  assign adv       = !stg_valid[DEPTH-1] || out_ready;
  assign in_ready  = ((MODE == PIPE_LOCKSTEP) ? adv : rdy[0]) && !flush && !reset;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = stg_valid[DEPTH-1];
  assign out_data  = stg_data[DEPTH-1];
  assign out_xfer  = out_valid && out_ready;

  // lockstep moves the whole chain at once; collapse moves each stage on its own ready
  always_comb begin
    load = '0;
    for (int i = 0; i < DEPTH; i++) begin
      load[i] = (MODE == PIPE_LOCKSTEP) ? adv : rdy[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             d_valid_s;
    logic [WIDTH-1:0] d_s;
    if (g == 0) begin : g_head
      assign d_valid_s = in_xfer;
      assign d_s       = in_data;
    end else begin : g_body
      assign d_valid_s = stg_valid[g-1];
      assign d_s       = stg_data[g-1];
    end
    pipe_stage #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .flush   (flush),
      .load    (load[g]),
      .d_valid (d_valid_s),
      .d       (d_s),
      .q_valid (stg_valid[g]),
      .q       (stg_data[g])
    );
  end

  // occupancy tracks transfers rather than counting valid bits
  always_comb begin
    occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
  end

  // occupancy register, cleared together with the stages
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - self-checking bench for pipe_reg_chain
module tb_pipe_reg_chain;
  import mips_pipe_pkg::*;

  localparam int          N = 5;
  localparam int          DEP   [N] = '{3, 3, 2, 4, 1};
  localparam bit          LOCK  [N] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [31:0] MASK  [N] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                        32'h0000_00FF, 32'h0000_FFFF};
  localparam logic [31:0] INITV [N] = '{32'h0, 32'h0, 32'h0, 32'hFF, 32'h1234};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst  [N];
  logic        fl   [N];
  logic        iv   [N];
  logic        ordy [N];
  logic [31:0] idat [N];
  logic        irdy [N];
  logic        ov   [N];
  logic [31:0] odat [N];
  logic [31:0] occ  [N];

  logic [31:0] od0, od1, od2;
  logic [7:0]  od3;
  logic [15:0] od4;
  logic [1:0]  oc0, oc1, oc2;
  logic [2:0]  oc3;
  logic        oc4;

  pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .INIT(32'h0), .MODE(PIPE_COLLAPSE)) u_dut0 (
    .clock(clock), .reset(rst[0]), .flush(fl[0]), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_data(idat[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0), .occupancy(oc0));
  pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .INIT(32'h0), .MODE(PIPE_LOCKSTEP)) u_dut1 (
    .clock(clock), .reset(rst[1]), .flush(fl[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_data(idat[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1), .occupancy(oc1));
  pipe_reg_chain #(.WIDTH(32), .DEPTH(2), .INIT(32'h0), .MODE(PIPE_COLLAPSE)) u_dut2 (
    .clock(clock), .reset(rst[2]), .flush(fl[2]), .in_valid(iv[2]), .in_ready(irdy[2]),
    .in_data(idat[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2), .occupancy(oc2));
  pipe_reg_chain #(.WIDTH(8), .DEPTH(4), .INIT(8'hFF), .MODE(PIPE_COLLAPSE)) u_dut3 (
    .clock(clock), .reset(rst[3]), .flush(fl[3]), .in_valid(iv[3]), .in_ready(irdy[3]),
    .in_data(idat[3][7:0]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od3), .occupancy(oc3));
  pipe_reg_chain #(.WIDTH(16), .DEPTH(1), .INIT(16'h1234), .MODE(PIPE_LOCKSTEP)) u_dut4 (
    .clock(clock), .reset(rst[4]), .flush(fl[4]), .in_valid(iv[4]), .in_ready(irdy[4]),
    .in_data(idat[4][15:0]), .out_valid(ov[4]), .out_ready(ordy[4]), .out_data(od4), .occupancy(oc4));

  assign odat[0] = od0;
  assign odat[1] = od1;
  assign odat[2] = od2;
  assign odat[3] = {24'h0, od3};
  assign odat[4] = {16'h0, od4};
  assign occ[0]  = {30'h0, oc0};
  assign occ[1]  = {30'h0, oc1};
  assign occ[2]  = {30'h0, oc2};
  assign occ[3]  = {29'h0, oc3};
  assign occ[4]  = {31'h0, oc4};

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h want %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // model: words in flight, oldest first, each with the stage position it occupies
  int          cnt   [N];
  int          mpos  [N][8];
  logic [31:0] mdat  [N][8];
  logic [31:0] mlast [N];

  function automatic bit m_ovalid(input int k);
    return (cnt[k] > 0) && (mpos[k][0] == DEP[k] - 1);
  endfunction

  function automatic bit m_irdy(input int k);
    if (rst[k] || fl[k]) return 1'b0;
    if (LOCK[k]) return !m_ovalid(k) || ordy[k];
    return (cnt[k] < DEP[k]) || ordy[k];
  endfunction

  task automatic m_step(input int k);
    bit ix, ox;
    int lim;
    ix = iv[k] && m_irdy(k);
    ox = m_ovalid(k) && ordy[k];
    if (rst[k] || fl[k]) begin
      cnt[k]   = 0;
      mlast[k] = INITV[k];
      return;
    end
    if (LOCK[k] && m_ovalid(k) && !ordy[k]) return;
    if (ox) begin
      for (int j = 0; j < cnt[k] - 1; j++) begin
        mpos[k][j] = mpos[k][j+1];
        mdat[k][j] = mdat[k][j+1];
      end
      cnt[k]--;
    end
    for (int j = 0; j < cnt[k]; j++) begin
      if (LOCK[k]) begin
        mpos[k][j]++;
      end else begin
        lim = (j == 0) ? DEP[k] - 1 : mpos[k][j-1] - 1;
        if (mpos[k][j] < lim) mpos[k][j]++;
      end
    end
    if (ix) begin
      mpos[k][cnt[k]] = 0;
      mdat[k][cnt[k]] = idat[k] & MASK[k];
      cnt[k]++;
    end
    if (m_ovalid(k)) mlast[k] = mdat[k][0];
  endtask

  always @(posedge clock) begin
    for (int k = 0; k < N; k++) m_step(k);
  end

  always @(negedge clock) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        chk("in_ready",  k, {31'h0, irdy[k]}, {31'h0, m_irdy(k)});
        chk("out_valid", k, {31'h0, ov[k]},   {31'h0, m_ovalid(k)});
        chk("out_data",  k, odat[k], mlast[k]);
        chk("occupancy", k, occ[k], cnt[k]);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic rst_one(input int k);
    rst[k] = 1'b1;
    cyc();
    rst[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b1; fl[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0; idat[k] = '0;
      cnt[k] = 0; mlast[k] = INITV[k];
    end
    cyc();
    for (int k = 0; k < N; k++) chk("rst_in_ready", k, {31'h0, irdy[k]}, 32'h0);
    chk_en = 1'b1;
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b0;
      chk("rst_out_valid", k, {31'h0, ov[k]}, 32'h0);
      chk("rst_occ",       k, occ[k], 32'h0);
      chk("rst_out_data",  k, odat[k], INITV[k]);
    end

    // stream 0x11,0x22,0x33 through depth 3 collapse
    ordy[0] = 1'b1; iv[0] = 1'b1; idat[0] = 32'h11;
    cyc(); chk("t1_ov_e1", 0, {31'h0, ov[0]}, 32'h0);
    idat[0] = 32'h22;
    cyc(); chk("t1_ov_e2", 0, {31'h0, ov[0]}, 32'h0);
    idat[0] = 32'h33;
    cyc(); iv[0] = 1'b0;
    chk("t1_ov_e3", 0, {31'h0, ov[0]}, 32'h1);
    chk("t1_data_e3", 0, odat[0], 32'h11);
    chk("t1_occ_peak", 0, occ[0], 32'h3);
    cyc(); chk("t1_data_e4", 0, odat[0], 32'h22);
    cyc(); chk("t1_data_e5", 0, odat[0], 32'h33);
    cyc(); chk("t1_ov_e6", 0, {31'h0, ov[0]}, 32'h0);

    // backpressure: fourth word waits upstream, then drains in order
    rst_one(0);
    ordy[0] = 1'b0; iv[0] = 1'b1; idat[0] = 32'hA;
    cyc(); idat[0] = 32'hB;
    cyc(); idat[0] = 32'hC;
    cyc(); idat[0] = 32'hD;
    #1;
    chk("t2_in_ready_full", 0, {31'h0, irdy[0]}, 32'h0);
    chk("t2_occ_full", 0, occ[0], 32'h3);
    cyc(); chk("t2_data_hold", 0, odat[0], 32'hA);
    ordy[0] = 1'b1;
    #1;
    chk("t2_in_ready_drain", 0, {31'h0, irdy[0]}, 32'h1);
    cyc(); iv[0] = 1'b0;
    chk("t2_data_b", 0, odat[0], 32'hB);
    cyc(); chk("t2_data_c", 0, odat[0], 32'hC);
    cyc(); chk("t2_data_d", 0, odat[0], 32'hD);
    cyc(); chk("t2_empty", 0, {31'h0, ov[0]}, 32'h0);
    ordy[0] = 1'b0;

    // bubble: collapse squeezes it out, lockstep keeps it
    rst[0] = 1'b1; rst[1] = 1'b1;
    cyc();
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin ordy[k] = 1'b0; iv[k] = 1'b1; idat[k] = 32'h1; end
    cyc();
    for (int k = 0; k < 2; k++) iv[k] = 1'b0;
    cyc();
    for (int k = 0; k < 2; k++) begin iv[k] = 1'b1; idat[k] = 32'h2; end
    cyc();
    for (int k = 0; k < 2; k++) iv[k] = 1'b0;
    #1;
    chk("t3_lock_in_ready", 1, {31'h0, irdy[1]}, 32'h0);
    chk("t3_lock_occ", 1, occ[1], 32'h2);
    cyc();
    chk("t3_coll_occ", 0, occ[0], 32'h2);
    chk("t3_coll_data", 0, odat[0], 32'h1);
    ordy[1] = 1'b1;
    cyc();
    chk("t3_lock_bubble", 1, {31'h0, ov[1]}, 32'h0);
    chk("t3_lock_occ2", 1, occ[1], 32'h1);
    ordy[1] = 1'b0;

    // flush a full chain while input is offered
    rst_one(0);
    ordy[0] = 1'b0; iv[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin idat[0] = 32'h5 + i; cyc(); end
    idat[0] = 32'h8; fl[0] = 1'b1;
    #1;
    chk("t4_in_ready_flush", 0, {31'h0, irdy[0]}, 32'h0);
    cyc(); fl[0] = 1'b0; iv[0] = 1'b0;
    chk("t4_occ", 0, occ[0], 32'h0);
    chk("t4_ov", 0, {31'h0, ov[0]}, 32'h0);
    chk("t4_data", 0, odat[0], 32'h0);

    // depth 2 collapse at full rate
    rst_one(2);
    ordy[2] = 1'b1; iv[2] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      idat[2] = 32'h100 + i;
      cyc();
      if (i >= 1) begin
        chk("t5_occ", 2, occ[2], 32'h2);
        chk("t5_data", 2, odat[2], 32'h100 + i - 1);
      end
    end
    iv[2] = 1'b0; ordy[2] = 1'b0;

    // reset mid-stream, then exact latency of the next word
    rst_one(3);
    ordy[3] = 1'b1; iv[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin idat[3] = i + 1; cyc(); end
    rst[3] = 1'b1;
    #1;
    chk("t6_in_ready_rst", 3, {31'h0, irdy[3]}, 32'h0);
    cyc(); rst[3] = 1'b0;
    chk("t6_ov", 3, {31'h0, ov[3]}, 32'h0);
    chk("t6_data", 3, odat[3], 32'hFF);
    chk("t6_occ", 3, occ[3], 32'h0);
    idat[3] = 32'h42;
    cyc(); iv[3] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("t6_lat_low", 3, {31'h0, ov[3]}, 32'h0);
      cyc();
    end
    chk("t6_lat_high", 3, {31'h0, ov[3]}, 32'h1);
    chk("t6_lat_data", 3, odat[3], 32'h42);

    // randomized traffic on every instance
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        rst[k]  = ($urandom_range(0, 149) == 0);
        fl[k]   = ($urandom_range(0, 59) == 0);
        iv[k]   = ($urandom_range(0, 3) != 0);
        ordy[k] = ((c / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        idat[k] = $urandom;
      end
      cyc();
    end
    for (int k = 0; k < N; k++) begin rst[k] = 1'b0; fl[k] = 1'b0; iv[k] = 1'b0; end
    cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
